rms_window_accum: RTL and testbench
===================================

# rms_window_accum

Sum-of-squares accumulator that sits directly downstream of the LFSR RMS sample mux in the SURF trigger RMS path. Each clock it takes the mux's 4-bit absolute-value sample, squares it, and adds it to a running sum. It produces a sum-of-squares result every 2^LOG2_WIN clocks, with no gaps between windows. Results are handed to the slow-side RMS/threshold logic over a valid/ready handshake.

## Interface
Parameters:
- LOG2_WIN, default 10: log2 of the window length N in clocks. Legal range 2..16.
- SYNC_DELAY, default 2: clocks from the sync_i edge to the first valid in_i sample. This covers LFSR start plus the mux output register. Legal range 0..15.
- ACC_W (localparam) = 8 + LOG2_WIN: result width.

Ports. One clock; reset is asynchronous and active-high.
- clk_i, in, 1: clock.
- rst_i, in, 1: asynchronous, active-high reset.
- sync_i, in, 1: start/restart pulse. This is the same pulse that starts the upstream mux.
- in_i, in, 4: absolute-value sample from the mux, unsigned.
- sum_o, out, ACC_W: sum of in_i² over the last completed window.
- sum_valid_o, out, 1: sum_o holds an unconsumed result.
- sum_ready_i, in, 1: consumer accepts; a transfer occurs when valid && ready on a clock edge.
- overrun_o, out, 1: sticky; set when a result was dropped.
- running_o, out, 1: high while in RUN.

## Operation
- Reset values: sum_o = 0, sum_valid_o = 0, overrun_o = 0, running_o = 0. Accumulator, square register and counters are all cleared. FSM goes to IDLE.
- FSM states:
  - IDLE: ignores in_i. sync_i moves it to ALIGN, or straight to RUN if SYNC_DELAY = 0.
  - ALIGN: counts SYNC_DELAY clocks, then moves to RUN.
  - RUN: free-running back-to-back windows until reset or sync_i.
- Datapath in RUN:
  - Stage 1 registers sq = in_i·in_i (8 bits, max 225) with a sample-valid flag.
  - Stage 2 adds sq into the accumulator.
  - The window counter counts samples 0..N-1 and wraps.
- End of window:
  - On the last square, acc + sq is loaded into the result register and the accumulator is set to 0 in the same cycle.
  - The next window's first square lands in the cleared accumulator. No sample is lost or double counted.
- Width: max sum = 225·2^LOG2_WIN < 2^ACC_W, so the accumulator cannot overflow. No saturation logic is needed.
- Handshake:
  - sum_valid_o rises when a result loads and falls on a transfer.
  - sum_o is stable while valid && !ready.
- Result arrives while valid is high and ready is low: the new result is dropped, the old sum_o is kept, and overrun_o is set.
- Result arrives in the same cycle as a transfer: the new result loads, valid stays high, and overrun_o is not set.
- sync_i in ALIGN or RUN:
  - Aborts the partial window: accumulator, counter and stage-1 valid are cleared, and the FSM re-enters ALIGN.
  - overrun_o is cleared.
  - A pending result and sum_valid_o are retained.
- sync_i in the same cycle as an end-of-window load: the load completes, then the restart proceeds.
- Asynchronous reset mid-window: everything returns to reset values immediately, including any pending result.

## Timing
- Edge numbering: sync_i is sampled high at edge E. The first sample is in_i at edge T0 = E + SYNC_DELAY. Sample k is captured at T0 + k.
- running_o is high from the cycle after E + SYNC_DELAY.
- Window w covers samples w·N .. w·N + N-1.
- The result for window w is visible (sum_valid_o high) after edge T0 + (w+1)·N + 1. Latency from the last sample to valid is 2 clocks.
- Results arrive every N clocks in steady state.
- The consumer must accept within N clocks to avoid overrun.

## Structure
- Shared package rms_pkg holds:
  - RMS_NBITS = 4 and RMS_SQ_W = 8.
  - Function rms_acc_w(log2_win), returning 8 + log2_win.
  - State enum rms_state_t with values IDLE, ALIGN, RUN.
- One sub-module, rms_window_ctrl: the FSM, the ALIGN delay counter and the window counter. It emits first/last strobes to the datapath in the top level.

## Test plan
- Constant 15 test:
  - Setup: LOG2_WIN = 4, SYNC_DELAY = 2, sync at E, ready held high.
  - Required: sum_o = 3600 and sum_valid_o high after edge E+19, and again every 16 clocks.
  - Required: sum_o = 3600 every window, with no gap samples.
- Ramp test (LOG2_WIN = 4): feed in_i = k mod 16 for k = 0..15.
  - Required: sum_o = 1240.
  - Next window fed all zeros: required sum_o = 0, which confirms the accumulator is cleared at the boundary.
- Backpressure test: hold ready low for 2 windows.
  - Required: first result retained; overrun_o = 1 after the second window end.
  - Raise ready in the exact cycle of the third window end: required no further overrun and the third result loaded.
- Mid-window sync: with in_i = 15, assert sync_i at sample 7 of a window.
  - Required: no result for the partial window.
  - Required: next result = 3600, valid after edge E' + 19.
  - Required: a pending unconsumed result is still presented.
- Reset test: assert rst_i asynchronously mid-window with a result pending.
  - Required: all outputs go to 0 immediately.
  - Required: after deassertion, no activity until the next sync_i.
- Maximum-size window: LOG2_WIN = 16 with in_i = 15.
  - Required: sum_o = 14745600 in 24 bits, with no wrap.

Source files
------------

// File: rtl/rms_pkg.sv
// Shared types and constants for the RMS sum-of-squares path.
package rms_pkg;

   localparam int RMS_NBITS = 4;
   localparam int RMS_SQ_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALIGN = 2'd1,
      RUN   = 2'd2
   } rms_state_t;

   function automatic int rms_acc_w(input int log2_win);
      return 8 + log2_win;
   endfunction

endpackage

// File: rtl/rms_window_ctrl.sv
// Sequencer for the window accumulator: IDLE/ALIGN/RUN FSM, sync-delay counter and
// window counter. Emits registered per-sample valid/first/last strobes.
module rms_window_ctrl
   import rms_pkg::*;
#(
   parameter int LOG2_WIN   = 10,
   parameter int SYNC_DELAY = 2
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sync,
   output logic       o_smp_vld,
   output logic       o_smp_first,
   output logic       o_smp_last,
   output rms_state_t o_state
);

   localparam int                  DLY_W    = 4;
   localparam logic [DLY_W-1:0]    DLY_LAST = DLY_W'((SYNC_DELAY == 0) ? 0 : SYNC_DELAY - 1);
   localparam logic [LOG2_WIN-1:0] WIN_LAST = '1;

   rms_state_t          r_state;
   logic [DLY_W-1:0]    r_dly_cnt;
   logic [LOG2_WIN-1:0] r_win_cnt;
   logic                r_smp_vld;
   logic                r_smp_first;
   logic                r_smp_last;

   logic                w_smp_en;
   logic [LOG2_WIN-1:0] w_cnt_cur;

   // A sync restarts the window count, and with no alignment delay the sync edge
   // itself captures sample 0 of the new window.
   always_comb begin
      w_cnt_cur = i_sync ? '0 : r_win_cnt;
      w_smp_en  = 1'b0;
      if (i_sync) begin
         w_smp_en = (SYNC_DELAY == 0);
      end else begin
         case (r_state)
            ALIGN:   w_smp_en = (r_dly_cnt == DLY_LAST);
            RUN:     w_smp_en = 1'b1;
            default: w_smp_en = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_dly_cnt   <= '0;
         r_win_cnt   <= '0;
         r_smp_vld   <= 1'b0;
         r_smp_first <= 1'b0;
         r_smp_last  <= 1'b0;
      end else begin
         r_smp_vld   <= w_smp_en;
         r_smp_first <= w_smp_en && (w_cnt_cur == '0);
         r_smp_last  <= w_smp_en && (w_cnt_cur == WIN_LAST);

         if (w_smp_en) begin
            r_win_cnt <= w_cnt_cur + 1'b1;
         end else if (i_sync) begin
            r_win_cnt <= '0;
         end

         if (i_sync) begin
            r_dly_cnt <= '0;
            if (SYNC_DELAY == 0) begin
               r_state <= RUN;
            end else begin
               r_state <= ALIGN;
            end
         end else begin
            case (r_state)
               ALIGN: begin
                  if (r_dly_cnt == DLY_LAST) begin
                     r_state <= RUN;
                  end else begin
                     r_dly_cnt <= r_dly_cnt + 1'b1;
                  end
               end
               default: r_state <= r_state;
            endcase
         end
      end
   end

   assign o_smp_vld   = r_smp_vld;
   assign o_smp_first = r_smp_first;
   assign o_smp_last  = r_smp_last;
   assign o_state     = r_state;

endmodule

// File: rtl/rms_window_accum.sv
// Windowed sum-of-squares of the 4-bit RMS mux sample: capture, square, accumulate,
// and hand each window result to the slow side over valid/ready.
module rms_window_accum
   import rms_pkg::*;
#(
   parameter  int LOG2_WIN   = 10,
   parameter  int SYNC_DELAY = 2,
   localparam int ACC_W      = rms_acc_w(LOG2_WIN)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 sync_i,
   input  logic [RMS_NBITS-1:0] in_i,
   output logic [ACC_W-1:0]     sum_o,
   output logic                 sum_valid_o,
   input  logic                 sum_ready_i,
   output logic                 overrun_o,
   output logic                 running_o
);

   logic                 w_smp_vld;
   logic                 w_smp_first;
   logic                 w_smp_last;
   rms_state_t           w_state;

   logic [RMS_NBITS-1:0] r_in;
   logic [RMS_SQ_W-1:0]  r_sq;
   logic                 r_sq_vld;
   logic                 r_sq_first;
   logic                 r_sq_last;
   logic [ACC_W-1:0]     r_acc;
   logic [ACC_W-1:0]     r_sum;
   logic                 r_sum_vld;
   logic                 r_overrun;

   logic [ACC_W-1:0]     w_acc_next;
   logic                 w_load;
   logic                 w_xfer;

   rms_window_ctrl #(
      .LOG2_WIN   (LOG2_WIN),
      .SYNC_DELAY (SYNC_DELAY)
   ) u_ctrl (
      .i_clk       (clk_i),
      .i_rst       (rst_i),
      .i_sync      (sync_i),
      .o_smp_vld   (w_smp_vld),
      .o_smp_first (w_smp_first),
      .o_smp_last  (w_smp_last),
      .o_state     (w_state)
   );

   // Capture and square stages; a sync drops whatever sample is between them.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_in       <= '0;
         r_sq       <= '0;
         r_sq_vld   <= 1'b0;
         r_sq_first <= 1'b0;
         r_sq_last  <= 1'b0;
      end else begin
         r_in       <= in_i;
         r_sq       <= RMS_SQ_W'(r_in) * RMS_SQ_W'(r_in);
         r_sq_vld   <= w_smp_vld && !sync_i;
         r_sq_first <= w_smp_first;
         r_sq_last  <= w_smp_last;
      end
   end

   // The first square of a window starts from zero so no earlier sum can leak in.
   assign w_acc_next = (r_sq_first ? '0 : r_acc) + ACC_W'(r_sq);
   assign w_load     = r_sq_vld && r_sq_last;
   assign w_xfer     = r_sum_vld && sum_ready_i;

   // Result handshake: sum_valid_o stays high until a clock edge sees it together with
   // sum_ready_i; sum_o never changes while valid is high and ready is low, and a
   // result landing in that state is dropped and flagged on overrun_o.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_acc     <= '0;
         r_sum     <= '0;
         r_sum_vld <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (sync_i || w_load) begin
            r_acc <= '0;
         end else if (r_sq_vld) begin
            r_acc <= w_acc_next;
         end

         if (w_load && (!r_sum_vld || w_xfer)) begin
            r_sum     <= w_acc_next;
            r_sum_vld <= 1'b1;
         end else if (w_xfer) begin
            r_sum_vld <= 1'b0;
         end

         if (sync_i) begin
            r_overrun <= 1'b0;
         end else if (w_load && r_sum_vld && !w_xfer) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign sum_o       = r_sum;
   assign sum_valid_o = r_sum_vld;
   assign overrun_o   = r_overrun;
   assign running_o   = (w_state == RUN);

endmodule

// File: tb/tb_rms_window_accum.sv
// Directed bench for rms_window_accum: a 16-sample window instance and a 65536-sample
// instance sharing one clock.
module tb_rms_window_accum;
   import rms_pkg::*;

   localparam int A_LOG2 = 4;
   localparam int A_W    = rms_acc_w(A_LOG2);
   localparam int B_LOG2 = 16;
   localparam int B_W    = rms_acc_w(B_LOG2);

   logic             clk = 1'b0;
   logic             rst_a, sync_a, ready_a;
   logic [3:0]       in_a;
   logic [A_W-1:0]   sum_a;
   logic             valid_a, ovr_a, run_a;
   logic             rst_b, sync_b, ready_b;
   logic [3:0]       in_b;
   logic [B_W-1:0]   sum_b;
   logic             valid_b, ovr_b, run_b;

   int               cyc   = 0;
   int               n_cmp = 0;
   int               n_err = 0;
   logic [31:0]      exp_q[$];

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rms_window_accum #(.LOG2_WIN(A_LOG2), .SYNC_DELAY(2)) u_dut_a (
      .clk_i       (clk),
      .rst_i       (rst_a),
      .sync_i      (sync_a),
      .in_i        (in_a),
      .sum_o       (sum_a),
      .sum_valid_o (valid_a),
      .sum_ready_i (ready_a),
      .overrun_o   (ovr_a),
      .running_o   (run_a)
   );

   rms_window_accum #(.LOG2_WIN(B_LOG2), .SYNC_DELAY(2)) u_dut_b (
      .clk_i       (clk),
      .rst_i       (rst_b),
      .sync_i      (sync_b),
      .in_i        (in_b),
      .sum_o       (sum_b),
      .sum_valid_o (valid_b),
      .sum_ready_i (ready_b),
      .overrun_o   (ovr_b),
      .running_o   (run_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) tick();
   endtask

   task automatic pulse_sync_a(output int e);
      sync_a = 1'b1;
      tick();
      sync_a = 1'b0;
      e = cyc;
   endtask

   initial begin
      int          e, ep, eb;
      logic        saw_valid, saw_run;
      logic [31:0] exp_v;

      rst_a = 1'b1; rst_b = 1'b1;
      sync_a = 1'b0; sync_b = 1'b0;
      ready_a = 1'b1; ready_b = 1'b1;
      in_a = 4'd0; in_b = 4'd15;
      repeat (3) tick();
      rst_a = 1'b0; rst_b = 1'b0;
      tick();

      // reset state
      check("rst_sum", 32'(sum_a), 0);
      check("rst_valid", 32'(valid_a), 0);
      check("rst_overrun", 32'(ovr_a), 0);
      check("rst_running", 32'(run_a), 0);
      check("rst_b_valid", 32'(valid_b), 0);

      // IDLE ignores input
      in_a = 4'd15;
      repeat (20) tick();
      check("idle_valid", 32'(valid_a), 0);
      check("idle_running", 32'(run_a), 0);

      // constant 15, both instances start on the same edge
      sync_a = 1'b1; sync_b = 1'b1;
      tick();
      sync_a = 1'b0; sync_b = 1'b0;
      e = cyc; eb = cyc;
      check("t1_run_e0", 32'(run_a), 0);
      tick();
      check("t1_run_e1", 32'(run_a), 0);
      tick();
      check("t1_run_e2", 32'(run_a), 1);
      for (int w = 0; w < 3; w++) exp_q.push_back(32'd3600);
      for (int w = 0; w < 3; w++) begin
         wait_cyc(e + 18 + 16 * w);
         check("t1_pre_valid", 32'(valid_a), 0);
         tick();
         exp_v = exp_q.pop_front();
         check("t1_valid", 32'(valid_a), 1);
         check("t1_sum", 32'(sum_a), exp_v);
      end

      // ramp 0..15 then a window of zeros
      pulse_sync_a(e);
      wait_cyc(e + 1);
      for (int k = 0; k < 16; k++) begin
         in_a = 4'(k);
         tick();
      end
      in_a = 4'd0;
      wait_cyc(e + 18);
      check("ramp_pre_valid", 32'(valid_a), 0);
      tick();
      check("ramp_valid", 32'(valid_a), 1);
      check("ramp_sum", 32'(sum_a), 1240);
      wait_cyc(e + 35);
      check("zero_valid", 32'(valid_a), 1);
      check("zero_sum", 32'(sum_a), 0);

      // backpressure: windows of 1, 2, 3, 4
      in_a = 4'd1;
      pulse_sync_a(e);
      tick();
      ready_a = 1'b0;
      wait_cyc(e + 17); in_a = 4'd2;
      wait_cyc(e + 19);
      check("bp_w0_valid", 32'(valid_a), 1);
      check("bp_w0_sum", 32'(sum_a), 16);
      check("bp_w0_ovr", 32'(ovr_a), 0);
      wait_cyc(e + 33); in_a = 4'd3;
      wait_cyc(e + 34); ready_a = 1'b1;
      wait_cyc(e + 35);
      check("bp_same_cycle_valid", 32'(valid_a), 1);
      check("bp_same_cycle_sum", 32'(sum_a), 64);
      check("bp_same_cycle_ovr", 32'(ovr_a), 0);
      ready_a = 1'b0;
      wait_cyc(e + 49); in_a = 4'd4;
      wait_cyc(e + 51);
      check("bp_drop_valid", 32'(valid_a), 1);
      check("bp_drop_sum_kept", 32'(sum_a), 64);
      check("bp_drop_ovr", 32'(ovr_a), 1);
      wait_cyc(e + 66); ready_a = 1'b1;
      wait_cyc(e + 67);
      check("bp_resume_valid", 32'(valid_a), 1);
      check("bp_resume_sum", 32'(sum_a), 256);
      check("bp_resume_ovr", 32'(ovr_a), 1);
      tick();
      check("bp_consumed", 32'(valid_a), 0);

      // mid-window sync with a pending result
      in_a = 4'd5;
      pulse_sync_a(e);
      check("ms_sync_clears_ovr", 32'(ovr_a), 0);
      tick();
      ready_a = 1'b0;
      wait_cyc(e + 17); in_a = 4'd15;
      wait_cyc(e + 19);
      check("ms_pend_sum", 32'(sum_a), 400);
      wait_cyc(e + 24);
      pulse_sync_a(ep);
      check("ms_pend_valid", 32'(valid_a), 1);
      check("ms_pend_kept", 32'(sum_a), 400);
      check("ms_align_running", 32'(run_a), 0);
      tick();
      ready_a = 1'b1;
      check("ms_still_presented", 32'(sum_a), 400);
      tick();
      check("ms_consumed", 32'(valid_a), 0);
      check("ms_running", 32'(run_a), 1);
      wait_cyc(ep + 10);
      check("ms_no_partial", 32'(valid_a), 0);
      wait_cyc(ep + 18);
      check("ms_pre_valid", 32'(valid_a), 0);
      tick();
      check("ms_valid", 32'(valid_a), 1);
      check("ms_sum", 32'(sum_a), 3600);
      ready_a = 1'b0;

      // asynchronous reset mid-window with a result pending
      wait_cyc(ep + 27);
      check("rr_pending", 32'(valid_a), 1);
      #3 rst_a = 1'b1;
      #1;
      check("rr_sum", 32'(sum_a), 0);
      check("rr_valid", 32'(valid_a), 0);
      check("rr_overrun", 32'(ovr_a), 0);
      check("rr_running", 32'(run_a), 0);
      #2 rst_a = 1'b0;
      ready_a = 1'b1;
      in_a = 4'd15;
      saw_valid = 1'b0;
      saw_run = 1'b0;
      repeat (40) begin
         tick();
         saw_valid = saw_valid | valid_a;
         saw_run = saw_run | run_a;
      end
      check("rr_quiet_valid", 32'(saw_valid), 0);
      check("rr_quiet_running", 32'(saw_run), 0);
      pulse_sync_a(e);
      wait_cyc(e + 18);
      check("rr_restart_pre", 32'(valid_a), 0);
      tick();
      check("rr_restart_valid", 32'(valid_a), 1);
      check("rr_restart_sum", 32'(sum_a), 3600);

      // maximum window on the second instance
      wait_cyc(eb + 65538);
      check("max_pre_valid", 32'(valid_b), 0);
      tick();
      check("max_valid", 32'(valid_b), 1);
      check("max_sum", 32'(sum_b), 14745600);
      check("max_ovr", 32'(ovr_b), 0);
      check("max_running", 32'(run_b), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
